// File: rtl/mcu_pkg.sv
// Shared MCU definitions: call/return sequencer states, operation kinds and
// stack geometry constants.
package mcu_pkg;

    localparam int             AW          = 11;
    localparam int             STACK_DEPTH = 16;
    localparam logic [AW-1:0]  IRQ_VECTOR  = 11'h004;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        OP_CALL,
        OP_RET,
        OP_RETFIE,
        OP_IRQ
    } op_t;

endpackage : mcu_pkg

// File: rtl/stack_seq.sv
// Call/return sequencer for the hardware return-address stack: arbitrates
// CALL/RET/RETFIE/IRQ, strobes the stack, loads the PC and tracks depth.
module stack_seq
    import mcu_pkg::*;
#(
    parameter int            AW         = mcu_pkg::AW,
    parameter int            DEPTH      = mcu_pkg::STACK_DEPTH,
    parameter logic [AW-1:0] IRQ_VECTOR = mcu_pkg::IRQ_VECTOR,
    localparam int           DW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic          retfie_req,
    input  logic          irq_req,
    input  logic [AW-1:0] call_target,
    input  logic [AW-1:0] pc_ret,
    input  logic [AW-1:0] stack_top,
    output logic          stack_push,
    output logic          stack_pop,
    output logic [AW-1:0] stack_din,
    output logic          pc_load,
    output logic [AW-1:0] pc_next,
    output logic          ack,
    output logic          gie,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err,
    input  logic          err_clr
);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t state, state_nx;
    op_t    kind, kind_nx;
    logic   irq_ok;
    logic   any_req;

    assign irq_ok  = irq_req & gie;
    assign any_req = irq_ok | retfie_req | ret_req | call_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kind  <= OP_CALL;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = EXEC;
                    if (irq_ok)          kind_nx = OP_IRQ;
                    else if (retfie_req) kind_nx = OP_RETFIE;
                    else if (ret_req)    kind_nx = OP_RET;
                    else                 kind_nx = OP_CALL;
                end
            end
            EXEC:    state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes decode only from state and latched kind, never from requests.
    always_comb begin
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        stack_din  = '0;
        pc_load    = 1'b0;
        pc_next    = '0;
        ack        = 1'b0;
        if (state == EXEC) begin
            ack     = 1'b1;
            pc_load = 1'b1;
            case (kind)
                OP_CALL: begin
                    stack_push = 1'b1;
                    stack_din  = pc_ret;
                    pc_next    = call_target;
                end
                OP_IRQ: begin
                    stack_push = 1'b1;
                    stack_din  = pc_ret;
                    pc_next    = IRQ_VECTOR;
                end
                OP_RET, OP_RETFIE: begin
                    stack_pop = 1'b1;
                    pc_next   = stack_top;
                end
                default: pc_next = '0;
            endcase
        end
    end

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == '0);

    logic ovf_set, unf_set;
    assign ovf_set = stack_push & full;
    assign unf_set = stack_pop & empty;

    // Depth saturates at both ends; the stack itself still wraps on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth   <= '0;
            gie     <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (stack_push && !full)
                depth <= depth + 1'b1;
            else if (stack_pop && !empty)
                depth <= depth - 1'b1;

            if (state == EXEC && kind == OP_IRQ)
                gie <= 1'b0;
            else if (state == EXEC && kind == OP_RETFIE)
                gie <= 1'b1;

            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            unf_err <= unf_set | (unf_err & ~err_clr);
        end
    end

endmodule : stack_seq
